// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO-to-stream burst reader.
package fifo_stream_reader_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StFlush = 2'd2
  } state_e;

  localparam int unsigned BufDepth = 4;
  localparam int unsigned BufPtrW  = $clog2(BufDepth);
  // One extra bit so a full buffer (count == BufDepth) is representable.
  localparam int unsigned BufCntW  = BufPtrW + 1;

endpackage

// File: rtl/fifo_stream_reader_buf.sv
// Small circular output buffer holding stream words and their last flags.
module fifo_stream_reader_buf
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned pDATA_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic                   i_push,
  input  logic [pDATA_WIDTH-1:0] i_push_data,
  input  logic                   i_push_last,
  input  logic                   i_pop,
  output logic [BufCntW-1:0]     o_occupancy,
  output logic                   o_valid,
  output logic [pDATA_WIDTH-1:0] o_data,
  output logic                   o_last
);

  logic [pDATA_WIDTH-1:0] r_data [BufDepth];
  logic [BufDepth-1:0]    r_last;
  logic [BufPtrW-1:0]     r_wptr;
  logic [BufPtrW-1:0]     r_rptr;
  logic [BufCntW-1:0]     r_count;
  logic                   w_push;
  logic                   w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && (r_count != BufCntW'(BufDepth));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < BufDepth; i++) r_data[i] <= '0;
      r_last  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_data[r_wptr] <= i_push_data;
        r_last[r_wptr] <= i_push_last;
        r_wptr         <= r_wptr + BufPtrW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + BufPtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + BufCntW'(1);
        2'b01:   r_count <= r_count - BufCntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_occupancy = r_count;
  assign o_valid     = (r_count != '0);
  // Zero the outputs while empty so stale words never leak onto the stream.
  assign o_data      = o_valid ? r_data[r_rptr] : '0;
  assign o_last      = o_valid && r_last[r_rptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads bursts from a fifo_sync read port and streams them out over valid/ready.
// Define FIFO_STREAM_READER_STATS_EN to add stall/starve cycle counters.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned pDATA_WIDTH = 16,
  parameter bit          pFWFT       = 1'b0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  output logic                   o_fifo_ren,
  input  logic [pDATA_WIDTH-1:0] i_fifo_rdata,
  input  logic                   i_fifo_empty,
  input  logic                   i_start,
  input  logic [15:0]            i_burst_len,
  input  logic                   i_abort,
  output logic                   o_m_valid,
  input  logic                   i_m_ready,
  output logic [pDATA_WIDTH-1:0] o_m_data,
  output logic                   o_m_last,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [15:0]            o_words_sent
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  output logic [31:0]            o_stall_cycles,
  output logic [31:0]            o_starve_cycles
`endif
);

  state_e       r_state;
  logic [15:0]  r_len;
  logic [15:0]  r_issued;
  logic         r_inflight;
  logic         r_inflight_last;
  logic         r_done;
  logic [15:0]  r_words_sent;

  logic [BufCntW-1:0] w_occ;
  logic               w_buf_valid;
  logic               w_buf_last;
  logic               w_inflight;
  logic               w_start_ok;
  logic               w_abort;
  logic               w_ren;
  logic               w_ren_last;
  logic               w_push;
  logic               w_push_last;
  logic               w_pop;
  logic               w_drained;

  assign w_start_ok = (r_state == StIdle) && i_start && !i_abort && (i_burst_len != '0);
  assign w_abort    = i_abort && (r_state != StIdle);
  assign w_inflight = pFWFT ? 1'b0 : r_inflight;

  // A read is only issued when its word is guaranteed a buffer slot on arrival.
  assign w_ren = (r_state == StRead) && !i_fifo_empty && !i_abort && (r_issued < r_len) &&
                 ((w_occ + BufCntW'(w_inflight)) < BufCntW'(BufDepth));
  assign w_ren_last = (r_issued == r_len - 16'd1);

  assign w_push      = (pFWFT ? w_ren : r_inflight) && !i_abort;
  assign w_push_last = pFWFT ? w_ren_last : r_inflight_last;
  assign w_pop       = w_buf_valid && i_m_ready;
  assign w_drained   = !w_push && ((w_occ == '0) || ((w_occ == BufCntW'(1)) && w_pop));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= StIdle;
      r_len           <= '0;
      r_issued        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
      r_words_sent    <= '0;
    end else begin
      r_done          <= 1'b0;
      r_inflight      <= !pFWFT && w_ren;
      r_inflight_last <= w_ren_last;
      if (w_ren) r_issued <= r_issued + 16'd1;
      if (w_pop) r_words_sent <= r_words_sent + 16'd1;
      unique case (r_state)
        StIdle: begin
          if (w_start_ok) begin
            r_state      <= StRead;
            r_len        <= i_burst_len;
            r_issued     <= '0;
            r_words_sent <= '0;
          end
        end
        StRead, StFlush: begin
          if (w_abort) begin
            r_state    <= StIdle;
            r_done     <= 1'b1;
            r_inflight <= 1'b0;
          end else if ((r_issued == r_len) && w_drained) begin
            r_state <= StIdle;
            r_done  <= 1'b1;
          end else if (r_issued == r_len) begin
            r_state <= StFlush;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  fifo_stream_reader_buf #(
    .pDATA_WIDTH(pDATA_WIDTH)
  ) u_buf (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (w_abort),
    .i_push     (w_push),
    .i_push_data(i_fifo_rdata),
    .i_push_last(w_push_last),
    .i_pop      (w_pop),
    .o_occupancy(w_occ),
    .o_valid    (w_buf_valid),
    .o_data     (o_m_data),
    .o_last     (w_buf_last)
  );

  assign o_fifo_ren   = w_ren;
  assign o_m_valid    = w_buf_valid;
  assign o_m_last     = w_buf_last;
  assign o_busy       = (r_state != StIdle);
  assign o_done       = r_done;
  assign o_words_sent = r_words_sent;

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_starve_cycles;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cycles  <= '0;
      r_starve_cycles <= '0;
    end else if (w_start_ok) begin
      r_stall_cycles  <= '0;
      r_starve_cycles <= '0;
    end else begin
      if (w_buf_valid && !i_m_ready && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if ((r_state == StRead) && i_fifo_empty && (w_occ == '0) && (r_starve_cycles != '1)) begin
        r_starve_cycles <= r_starve_cycles + 32'd1;
      end
    end
  end

  assign o_stall_cycles  = r_stall_cycles;
  assign o_starve_cycles = r_starve_cycles;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomised bench for fifo_stream_reader against a transaction-level stream model.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        ren;
  logic        fifo_empty;
  logic [15:0] fifo_rdata = '0;
  logic        start;
  logic [15:0] burst_len;
  logic        abort;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;
  logic        busy;
  logic        done;
  logic [15:0] words_sent;
`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] starve_cycles;
`endif

  always #5 clk = ~clk;

  fifo_stream_reader dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .o_fifo_ren  (ren),
    .i_fifo_rdata(fifo_rdata),
    .i_fifo_empty(fifo_empty),
    .i_start     (start),
    .i_burst_len (burst_len),
    .i_abort     (abort),
    .o_m_valid   (m_valid),
    .i_m_ready   (m_ready),
    .o_m_data    (m_data),
    .o_m_last    (m_last),
    .o_busy      (busy),
    .o_done      (done),
    .o_words_sent(words_sent)
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    .o_stall_cycles (stall_cycles),
    .o_starve_cycles(starve_cycles)
`endif
  );

  // Source FIFO with registered read data (rdata valid the cycle after ren).
  logic [15:0] fifo_mem [256];
  logic [7:0]  wr_ptr = '0;
  logic [7:0]  rd_ptr = '0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (ren && !fifo_empty) begin
      fifo_rdata <= fifo_mem[rd_ptr];
      rd_ptr     <= rd_ptr + 8'd1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Stream model state: a burst is the next len words of the source FIFO in order.
  int          cyc = 0;
  bit          active = 0;
  bit          exp_done = 0;
  logic [15:0] ws_m = '0;
  logic [7:0]  base = '0;
  int          len = 0;
  int          acc = 0;
  int          start_cyc = 0;
  int          first_valid = -1;
  int          last_acc = 0;
  int          done_cnt = 0;
  bit          prev_stall = 0;
  logic [15:0] prev_data = '0;
  logic        prev_last = 1'b0;
  logic [31:0] stall_m = '0;

  task automatic sample();
    bit         xfer, start_ok, stall_now;
    int         issued;
    logic [7:0] idx;
    if (rst) begin
      check_eq("rst_ren", ren, 0);
      check_eq("rst_valid", m_valid, 0);
      check_eq("rst_last", m_last, 0);
      check_eq("rst_data", m_data, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_words", words_sent, 0);
`ifdef FIFO_STREAM_READER_STATS_EN
      check_eq("rst_stall", stall_cycles, 0);
      check_eq("rst_starve", starve_cycles, 0);
`endif
      active = 0; exp_done = 0; ws_m = '0; prev_stall = 0; stall_m = '0;
      return;
    end
    xfer = m_valid && m_ready;
    check_eq("done", done, exp_done);
    check_eq("busy", busy, active);
    check_eq("words_sent", words_sent, ws_m);
`ifdef FIFO_STREAM_READER_STATS_EN
    check_eq("stall_cycles", stall_cycles, stall_m);
`endif
    if (done) done_cnt++;
    if (!active) begin
      check_eq("idle_valid", m_valid, 0);
      check_eq("idle_ren", ren, 0);
    end else begin
      issued = int'(8'(rd_ptr - base));
      if (prev_stall) begin
        check_eq("hold_valid", m_valid, 1);
        check_eq("hold_data", m_data, prev_data);
        check_eq("hold_last", m_last, prev_last);
      end
      if (ren) begin
        check_eq("ren_room", (issued - acc) < 4, 1);
        check_eq("ren_len", issued < len, 1);
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (xfer) begin
        idx = base + 8'(acc);
        check_eq("data", m_data, fifo_mem[idx]);
        check_eq("last", m_last, (acc + 1) == len);
        acc++;
        last_acc = cyc;
      end
    end
    stall_now = active && !abort && m_valid && !m_ready;
    start_ok  = start && !abort && !active && (burst_len != 16'd0);
    if (start_ok) stall_m = '0;
    else if (m_valid && !m_ready) stall_m = stall_m + 32'd1;
    if (start_ok) ws_m = '0;
    else if (xfer) ws_m = ws_m + 16'd1;
    exp_done = 0;
    if (active && (abort || (xfer && acc == len))) begin
      exp_done = 1;
      active   = 0;
    end
    if (start_ok) begin
      active = 1; base = rd_ptr; len = int'(burst_len); acc = 0;
      start_cyc = cyc; first_valid = -1;
    end
    prev_stall = stall_now;
    prev_data  = m_data;
    prev_last  = m_last;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic fifo_wr(input logic [15:0] v);
    fifo_mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  // mode: 0 ready high, 1 toggle, 2 random with stray starts, 3 hold low 7 valid cycles.
  task automatic set_ready(input int mode);
    case (mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      2:       m_ready = ($urandom_range(0, 3) != 0);
      default: m_ready = (first_valid >= 0) && ((cyc - first_valid) >= 7);
    endcase
  endtask

  task automatic run_burst(input int blen, input int extra, input int mode,
                           input int abort_after, input int hold_at);
    int d0, n, held;
    bit aborted;
    d0 = done_cnt; n = 0; held = 0; aborted = 0;
    burst_len = 16'(blen);
    start     = 1'b1;
    set_ready(mode);
    tick();
    start = 1'b0;
    while (done_cnt == d0 && n < 500) begin
      set_ready(mode);
      abort = 1'b0;
      if (abort_after >= 0 && !aborted && acc >= abort_after) begin
        abort   = 1'b1;
        aborted = 1;
      end
      if (mode == 2 && !aborted && acc < blen) begin
        start     = ($urandom_range(0, 15) == 0);
        burst_len = 16'($urandom_range(1, 20));
      end
      if (extra > 0) begin
        if (hold_at < 0) begin
          if ($urandom_range(0, 1) == 1) begin
            fifo_wr(16'($urandom));
            extra--;
          end
        end else if (acc >= hold_at) begin
          held++;
          if (held > 10) begin
            for (int i = 0; i < extra; i++) fifo_wr(16'(16'h0100 + i));
            extra = 0;
          end
        end
      end
      tick();
      start = 1'b0;
      n++;
    end
    abort = 1'b0;
    check_eq("burst_done", done_cnt - d0, 1);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; burst_len = '0; abort = 1'b0; m_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Zero length, and start together with abort, must both be ignored.
    burst_len = 16'd0; start = 1'b1;
    tick();
    burst_len = 16'd5; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (2) tick();

    for (int i = 1; i <= 8; i++) fifo_wr(16'(i));
    run_burst(8, 0, 0, -1, -1);
    check_eq("latency", first_valid - start_cyc, 3);
    check_eq("throughput", last_acc - first_valid, 7);
    check_eq("count8", acc, 8);

    for (int i = 1; i <= 5; i++) fifo_wr(16'(i));
    run_burst(5, 0, 1, -1, -1);
    check_eq("count5", acc, 5);

    for (int i = 1; i <= 3; i++) fifo_wr(16'(16'h0010 + i));
    run_burst(6, 3, 0, -1, 3);
    check_eq("count6", acc, 6);

    for (int i = 1; i <= 10; i++) fifo_wr(16'(16'h0020 + i));
    run_burst(10, 0, 0, 2, -1);
    tick();
    check_eq("abort_left", 8'(wr_ptr - rd_ptr) >= 8'd4, 1);

    for (int i = 1; i <= 8; i++) fifo_wr(16'(16'h0040 + i));
    burst_len = 16'd8; start = 1'b1; m_ready = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (acc < 3 && n < 100) begin
      tick();
      n++;
    end
    check_eq("pre_rst_acc", acc >= 3, 1);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    run_burst(4, 0, 0, -1, -1);
    check_eq("post_rst_count", acc, 4);

    run_burst(3, 3, 3, -1, -1);
`ifdef FIFO_STREAM_READER_STATS_EN
    check_eq("stall7", stall_cycles, 7);
`endif

    for (int b = 0; b < 20; b++) begin
      int l, p, ab;
      l  = $urandom_range(1, 12);
      p  = $urandom_range(0, l);
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, l - 1) : -1;
      for (int i = 0; i < p; i++) fifo_wr(16'($urandom));
      run_burst(l, l - p, 2, ab, -1);
      repeat (2) tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
